// File: rtl/usiq_frame_builder.sv
// usiq_frame_builder: serialises 24-bit IQ/mic samples MSB-first into fixed-length byte frames
// of 3 sync bytes, 5 latched control bytes (C0..C4) and NSAMP samples.
module usiq_frame_builder #(
  parameter int         NSAMP     = 168,
  parameter logic [7:0] SYNC_BYTE = 8'h7F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic [10:0] in_tlength,
  input  logic [39:0] cc_data,
  output logic        cc_ack,
  output logic [7:0]  out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic [15:0] frame_count
);

  localparam int FLEN  = 8 + 3 * NSAMP;
  localparam int IDX_W = $clog2(FLEN);
  localparam logic [IDX_W-1:0] IDX_SYNC_END = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CTRL_END = IDX_W'(7);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FLEN - 1);
  localparam logic [10:0]      FRAME_WORDS  = 11'(NSAMP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_CTRL = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] idx_r;
  logic [1:0]       lane_r;
  logic [39:0]      cc_r;
  logic [15:0]      frame_count_r;
  logic             start_s;
  logic             beat_s;
  logic             last_beat_s;

  // A frame may only start once a whole frame of samples is buffered, so DATA never underruns.
  assign start_s     = !rst && (state_r == ST_IDLE) && in_tvalid && (in_tlength >= FRAME_WORDS);
  assign beat_s      = out_tvalid & out_tready;
  assign last_beat_s = beat_s && (state_r == ST_DATA) && (idx_r == IDX_LAST);
  assign cc_ack      = start_s;
  assign in_tready   = beat_s && (state_r == ST_DATA) && (lane_r == 2'd2);
  assign frame_count = frame_count_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: each section advances on the handshake of its final byte index.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_next_s = ST_SYNC;
        else         state_next_s = ST_IDLE;
      end
      ST_SYNC: begin
        if (beat_s && (idx_r == IDX_SYNC_END)) state_next_s = ST_CTRL;
        else                                   state_next_s = ST_SYNC;
      end
      ST_CTRL: begin
        if (beat_s && (idx_r == IDX_CTRL_END)) state_next_s = ST_DATA;
        else                                   state_next_s = ST_CTRL;
      end
      ST_DATA: begin
        if (last_beat_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_DATA;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output byte mux; an empty FIFO in DATA drops out_tvalid rather than emitting a stale byte.
  always_comb begin
    out_tvalid = 1'b0;
    out_tdata  = 8'h00;
    out_tlast  = 1'b0;
    case (state_r)
      ST_SYNC: begin
        out_tvalid = 1'b1;
        out_tdata  = SYNC_BYTE;
      end
      ST_CTRL: begin
        out_tvalid = 1'b1;
        case (idx_r[2:0])
          3'd3:    out_tdata = cc_r[39:32];
          3'd4:    out_tdata = cc_r[31:24];
          3'd5:    out_tdata = cc_r[23:16];
          3'd6:    out_tdata = cc_r[15:8];
          default: out_tdata = cc_r[7:0];
        endcase
      end
      ST_DATA: begin
        out_tvalid = in_tvalid;
        if (in_tvalid) begin
          out_tlast = (idx_r == IDX_LAST);
          case (lane_r)
            2'd0:    out_tdata = in_tdata[23:16];
            2'd1:    out_tdata = in_tdata[15:8];
            default: out_tdata = in_tdata[7:0];
          endcase
        end else begin
          out_tdata = 8'h00;
        end
      end
      default: begin
        out_tvalid = 1'b0;
        out_tdata  = 8'h00;
      end
    endcase
  end

  // Byte index, sample lane, control latch and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r         <= '0;
      lane_r        <= 2'd0;
      cc_r          <= 40'h0;
      frame_count_r <= 16'h0;
    end else begin
      if (start_s) begin
        cc_r   <= cc_data;
        idx_r  <= '0;
        lane_r <= 2'd0;
      end else if (beat_s) begin
        idx_r <= idx_r + IDX_W'(1);
        if (state_r == ST_DATA) begin
          lane_r <= (lane_r == 2'd2) ? 2'd0 : lane_r + 2'd1;
        end else begin
          lane_r <= lane_r;
        end
      end else begin
        idx_r <= idx_r;
      end
      if (last_beat_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

endmodule

// File: tb/tb_usiq_frame_builder.sv
// Randomised bench for usiq_frame_builder: a queue models the show-ahead FIFO and each frame's
// expected byte image is built from the buffered samples and cc_data at the moment it starts.
module tb_usiq_frame_builder;

  localparam int NSAMP = 168;
  localparam int FLEN  = 8 + 3 * NSAMP;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic [10:0] in_tlength;
  logic [39:0] cc_data;
  logic        cc_ack;
  logic [7:0]  out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  usiq_frame_builder #(.NSAMP(NSAMP), .SYNC_BYTE(8'h7F)) dut (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlength(in_tlength),
    .cc_data(cc_data), .cc_ack(cc_ack),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .frame_count(frame_count)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] fifo [$];
  logic [7:0]  exp_frame [0:FLEN-1];
  bit          in_frame = 1'b0;
  int          pos = 0;
  int          fc_m = 0;
  int          pops = 0;
  int          force_cnt = 0;
  bit          rand_ready = 1'b0;
  int          rst_age = 0;
  bit          ack_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic build_frame();
    logic [23:0] s;
    for (int i = 0; i < 3; i++) exp_frame[i] = 8'h7F;
    for (int k = 0; k < 5; k++) exp_frame[3 + k] = cc_data[39 - 8 * k -: 8];
    for (int j = 0; j < NSAMP; j++) begin
      s = fifo[j];
      exp_frame[8 + 3 * j]     = s[23:16];
      exp_frame[8 + 3 * j + 1] = s[15:8];
      exp_frame[8 + 3 * j + 2] = s[7:0];
    end
  endtask

  // One clock cycle: drive at the falling edge, check #1 later, advance the model.
  task automatic cycle();
    logic exp_ack, exp_v, exp_rdy;
    in_tvalid  = (fifo.size() > 0) && (force_cnt == 0);
    in_tdata   = (fifo.size() > 0) ? fifo[0] : 24'h0;
    in_tlength = 11'(fifo.size());
    out_tready = rst ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    ack_seen = cc_ack;
    if (rst) begin
      if (rst_age > 0) begin
        check_eq("rst_cc_ack", cc_ack, 1'b0);
        check_eq("rst_tvalid", out_tvalid, 1'b0);
        check_eq("rst_tdata", out_tdata, 8'h00);
        check_eq("rst_tlast", out_tlast, 1'b0);
        check_eq("rst_in_tready", in_tready, 1'b0);
        check_eq("rst_frame_count", frame_count, 16'h0);
      end
      rst_age++;
      in_frame = 1'b0;
      pos      = 0;
      fc_m     = 0;
    end else begin
      rst_age = 0;
      exp_ack = !in_frame && in_tvalid && (fifo.size() >= NSAMP);
      exp_v   = in_frame && ((pos < 8) || in_tvalid);
      exp_rdy = exp_v && out_tready && (pos >= 8) && (((pos - 8) % 3) == 2);
      check_eq("cc_ack", cc_ack, exp_ack);
      check_eq("out_tvalid", out_tvalid, exp_v);
      check_eq("in_tready", in_tready, exp_rdy);
      check_eq("frame_count", frame_count, 16'(fc_m));
      if (exp_v && out_tvalid) begin
        check_eq("out_tdata", out_tdata, exp_frame[pos]);
        check_eq("out_tlast", out_tlast, pos == FLEN - 1);
      end
      if (exp_ack) begin
        build_frame();
        in_frame = 1'b1;
        pos      = 0;
      end else if (exp_v && out_tready) begin
        if (pos == FLEN - 1) begin
          in_frame = 1'b0;
          fc_m++;
        end
        pos++;
      end
    end
    if (in_tready && (fifo.size() > 0)) begin
      void'(fifo.pop_front());
      pops++;
    end
    if (force_cnt > 0) force_cnt--;
    @(negedge clk);
  endtask

  task automatic run_frames(input int target, input int budget);
    int b = budget;
    while ((fc_m != target) && (b > 0)) begin
      cycle();
      b--;
    end
    if (fc_m != target) check_eq("timeout_frames", frame_count, 16'(target));
  endtask

  task automatic run_until_pos(input int p, input int budget);
    int b = budget;
    while (!(in_frame && (pos == p)) && (b > 0)) begin
      cycle();
      b--;
    end
    if (!(in_frame && (pos == p))) check_eq("timeout_pos", 32'(pos), 32'(p));
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) fifo.push_back(24'($urandom));
  endtask

  initial begin
    rst        = 1'b1;
    cc_data    = 40'hA1B2C3D4E5;
    in_tdata   = 24'h0;
    in_tvalid  = 1'b0;
    in_tlength = 11'h0;
    out_tready = 1'b0;
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b0;

    // T1: ramp samples, always ready
    for (int i = 1; i <= NSAMP; i++) fifo.push_back(24'(i));
    run_frames(1, 2000);
    check_eq("t1_pops", 32'(pops), 32'(NSAMP));

    // T2: one sample short of a frame, then the last one arrives
    push_rand(NSAMP - 1);
    repeat (20) cycle();
    check_eq("t2_no_frame", frame_count, 16'd1);
    push_rand(1);
    cycle();
    check_eq("t2_start", ack_seen, 1'b1);
    run_frames(2, 2000);

    // T3: three back-to-back frames with random backpressure
    pops       = 0;
    rand_ready = 1'b1;
    push_rand(3 * NSAMP);
    run_frames(5, 8000);
    check_eq("t3_pops", 32'(pops), 32'(3 * NSAMP));
    check_eq("t3_frame_count", frame_count, 16'd5);

    // T4: cc_data changes right after it is latched
    rand_ready = 1'b0;
    cc_data    = 40'h0102030405;
    push_rand(2 * NSAMP);
    begin
      int b = 100;
      ack_seen = 1'b0;
      while (!ack_seen && (b > 0)) begin
        cycle();
        b--;
      end
      check_eq("t4_ack", ack_seen, 1'b1);
    end
    cc_data = 40'hFFFFFFFFFF;
    run_frames(7, 3000);

    // T5: reset in the middle of a frame
    push_rand(NSAMP);
    rand_ready = 1'b1;
    run_until_pos(100, 1000);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    rand_ready = 1'b0;
    push_rand(NSAMP);
    run_frames(1, 2000);

    // T6: FIFO goes invalid for 5 cycles mid-DATA
    push_rand(NSAMP - fifo.size());
    run_until_pos(200, 1000);
    force_cnt = 5;
    run_frames(2, 2000);
    check_eq("t6_fifo_empty", 32'(fifo.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
